// File: rtl/legup_mult_pkg.sv
// legup_mult_pkg: shared limits and the in-flight tag record for the multiplier arbiter
package legup_mult_pkg;
    localparam int MAX_REQ = 8;
    localparam int MAX_PIPE = 8;
    localparam int ID_W = $clog2(MAX_REQ);
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/legup_mult_pipelined.sv
// legup_mult_pipelined: multiplier with a fixed result latency of pipeline cycles
module legup_mult_pipelined #(
    parameter int    widtha         = 32,
    parameter int    widthb         = 32,
    parameter int    widthp         = 64,
    parameter int    pipeline       = 3,
    parameter string representation = "UNSIGNED"
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              clken,
    input  logic [widtha-1:0] dataa,
    input  logic [widthb-1:0] datab,
    output logic [widthp-1:0] result
);
    localparam int WF = widtha + widthb;
    logic [widthp-1:0] prod;
    logic [widthp-1:0] stage [pipeline];
    generate
        if (representation == "SIGNED") begin : g_s
            logic signed [WF-1:0] full;
            assign full = WF'($signed(dataa)) * WF'($signed(datab));
            assign prod = widthp'(full);
        end else begin : g_u
            logic [WF-1:0] full;
            assign full = WF'(dataa) * WF'(datab);
            assign prod = widthp'(full);
        end
    endgenerate
    always_ff @(posedge clock) begin
        if (aclr) begin
            for (int i = 0; i < pipeline; i++) stage[i] <= '0;
        end else if (clken) begin
            stage[0] <= prod;
            for (int i = 1; i < pipeline; i++) stage[i] <= stage[i-1];
        end
    end
    assign result = stage[pipeline-1];
endmodule

// File: rtl/legup_rr_arbiter.sv
// legup_rr_arbiter: round-robin one-hot grant searching upward from a rotating pointer
module legup_rr_arbiter #(
    parameter int num_req = 4,
    localparam int IW = $clog2(num_req)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [num_req-1:0] valid,
    output logic [num_req-1:0] grant,
    output logic [IW-1:0]      id,
    output logic               fire
);
    logic [IW-1:0] ptr;
    logic          hit;
    // Scan from the farthest offset down so the nearest valid requester wins last.
    always_comb begin
        hit = 1'b0;
        id = '0;
        for (int k = num_req - 1; k >= 0; k--)
            if (valid[IW'((int'(ptr) + k) % num_req)]) begin
                hit = 1'b1;
                id = IW'((int'(ptr) + k) % num_req);
            end
    end
    assign fire = hit & ~reset;
    assign grant = fire ? num_req'(1) << id : '0;
    always_ff @(posedge clock) begin
        if (reset) ptr <= '0;
        else if (hit) ptr <= (int'(id) == num_req - 1) ? '0 : id + 1'b1;
    end
endmodule

// File: rtl/legup_mult_arbiter.sv
// legup_mult_arbiter: shares one pipelined multiplier among num_req requesters, tagging results by owner
module legup_mult_arbiter
    import legup_mult_pkg::*;
#(
    parameter int    widtha         = 32,
    parameter int    widthb         = 32,
    parameter int    widthp         = 64,
    parameter int    pipeline       = 3,
    parameter string representation = "UNSIGNED",
    parameter int    num_req        = 4,
    localparam int   IW             = $clog2(num_req)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [num_req-1:0]        req_valid,
    output logic [num_req-1:0]        req_ready,
    input  logic [num_req*widtha-1:0] req_dataa,
    input  logic [num_req*widthb-1:0] req_datab,
    output logic                      res_valid,
    output logic [IW-1:0]             res_id,
    output logic [widthp-1:0]         res_data,
    output logic                      busy,
    output logic [31:0]               issue_count
);
    logic [IW-1:0]     gid;
    logic              fire;
    logic [widthp-1:0] product;
    logic [widthp-1:0] held;
    tag_t              tags [pipeline];

    legup_rr_arbiter #(.num_req(num_req)) u_arb (
        .clock(clock),
        .reset(reset),
        .valid(req_valid),
        .grant(req_ready),
        .id(gid),
        .fire(fire)
    );

    legup_mult_pipelined #(
        .widtha(widtha),
        .widthb(widthb),
        .widthp(widthp),
        .pipeline(pipeline),
        .representation(representation)
    ) u_mult (
        .clock(clock),
        .aclr(1'b0),
        .clken(1'b1),
        .dataa(req_dataa[gid*widtha +: widtha]),
        .datab(req_datab[gid*widthb +: widthb]),
        .result(product)
    );

    // Tags travel in lockstep with the multiplier stages; reset drops in-flight work.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < pipeline; i++) tags[i] <= '0;
            issue_count <= '0;
        end else begin
            tags[0] <= tag_t'{valid: fire, id: ID_W'(gid)};
            for (int i = 1; i < pipeline; i++) tags[i] <= tags[i-1];
            if (fire) issue_count <= issue_count + 32'd1;
        end
        if (res_valid) held <= product;
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < pipeline; i++) busy = busy | tags[i].valid;
        busy = busy & ~reset;
    end

    assign res_valid = tags[pipeline-1].valid & ~reset;
    assign res_id = reset ? '0 : tags[pipeline-1].id[IW-1:0];
    assign res_data = res_valid ? product : held;
endmodule

// File: tb/tb_legup_mult_arbiter.sv
// tb_legup_mult_arbiter: directed stimulus with a queue scoreboard checked by a negedge monitor
module tb_legup_mult_arbiter;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req_valid, req_ready, s_valid, s_ready;
    logic [127:0] req_dataa, req_datab, s_dataa, s_datab;
    logic         res_valid, s_res_valid, busy, s_busy;
    logic [1:0]   res_id, s_res_id;
    logic [63:0]  res_data, s_res_data;
    logic [31:0]  issue_count, s_issue_count;

    typedef struct {
        int          cyc;
        logic [1:0]  id;
        logic [63:0] data;
    } exp_t;

    exp_t q[$];
    exp_t sq[$];
    exp_t e, se;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int ids[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [63:0] prods[4] = '{64'd20, 64'd33, 64'd48, 64'd65};

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    legup_mult_arbiter dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_dataa(req_dataa), .req_datab(req_datab), .res_valid(res_valid),
        .res_id(res_id), .res_data(res_data), .busy(busy), .issue_count(issue_count)
    );

    legup_mult_arbiter #(.representation("SIGNED")) sdut (
        .clock(clock), .reset(reset), .req_valid(s_valid), .req_ready(s_ready),
        .req_dataa(s_dataa), .req_datab(s_datab), .res_valid(s_res_valid),
        .res_id(s_res_id), .res_data(s_res_data), .busy(s_busy), .issue_count(s_issue_count)
    );

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(negedge clock) begin
        if (res_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_res: res_valid=1 id=%0d at cycle %0d, expected no result", res_id, cyc);
            end else begin
                e = q.pop_front();
                check("res_cycle", 64'(cyc), 64'(e.cyc));
                check("res_id", 64'(res_id), 64'(e.id));
                check("res_data", res_data, e.data);
            end
        end
        if (s_res_valid === 1'b1) begin
            if (sq.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_s_res: s_res_valid=1 at cycle %0d, expected no result", cyc);
            end else begin
                se = sq.pop_front();
                check("s_res_cycle", 64'(cyc), 64'(se.cyc));
                check("s_res_id", 64'(s_res_id), 64'(se.id));
                check("s_res_data", s_res_data, se.data);
            end
        end
    end

    task automatic set_req(int i, logic [31:0] a, logic [31:0] b);
        req_dataa[i*32 +: 32] = a;
        req_datab[i*32 +: 32] = b;
    endtask

    task automatic push(int id, logic [63:0] d);
        q.push_back('{cyc + 3, 2'(id), d});
    endtask

    initial begin
        req_valid = 4'hF;
        req_dataa = '0;
        req_datab = '0;
        s_valid = 4'hF;
        s_dataa = '0;
        s_datab = '0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_res_valid", 64'(res_valid), 64'h0);
        check("rst_res_id", 64'(res_id), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_count", 64'(issue_count), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        req_valid = '0;
        s_valid = '0;
        // single request from requester 2, plus a signed product on the second instance
        @(negedge clock);
        set_req(2, 32'd7, 32'd9);
        req_valid = 4'b0100;
        s_dataa[31:0] = 32'hFFFF_FFFD;
        s_datab[31:0] = 32'd5;
        s_valid = 4'b0001;
        #1;
        check("single_ready", 64'(req_ready), 64'h4);
        check("signed_ready", 64'(s_ready), 64'h1);
        push(2, 64'd63);
        sq.push_back('{cyc + 3, 2'd0, 64'hFFFF_FFFF_FFFF_FFF1});
        @(negedge clock);
        req_valid = '0;
        s_valid = '0;
        #1;
        check("single_busy", 64'(busy), 64'h1);
        repeat (5) @(negedge clock);
        check("idle_busy", 64'(busy), 64'h0);
        check("single_count", 64'(issue_count), 64'h1);
        // pointer sits at 3: grant 3, then wrap to 0
        set_req(3, 32'd4, 32'd5);
        set_req(0, 32'd6, 32'd6);
        req_valid = 4'b1001;
        #1;
        check("wrap_ready3", 64'(req_ready), 64'h8);
        push(3, 64'd20);
        @(negedge clock);
        #1;
        check("wrap_ready0", 64'(req_ready), 64'h1);
        push(0, 64'd36);
        @(negedge clock);
        req_valid = '0;
        repeat (5) @(negedge clock);
        // two issues then reset: both must vanish
        set_req(1, 32'd2, 32'd2);
        req_valid = 4'b0010;
        #1;
        check("mid_ready1", 64'(req_ready), 64'h2);
        @(negedge clock);
        req_valid = 4'b0100;
        #1;
        check("mid_ready2", 64'(req_ready), 64'h4);
        check("mid_busy", 64'(busy), 64'h1);
        @(negedge clock);
        reset = 1'b1;
        req_valid = 4'hF;
        #1;
        check("rst_hi_ready", 64'(req_ready), 64'h0);
        check("rst_hi_busy", 64'(busy), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("post_rst_busy", 64'(busy), 64'h0);
            check("post_rst_count", 64'(issue_count), 64'h0);
            @(negedge clock);
        end
        // all four valid for eight cycles
        for (int i = 0; i < 4; i++) set_req(i, 32'(i + 2), 32'(i + 10));
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_ready", 64'(req_ready), 64'(4'(1) << ids[k]));
            push(ids[k], prods[ids[k]]);
            @(negedge clock);
        end
        req_valid = '0;
        #1;
        check("rr_count", 64'(issue_count), 64'd8);
        repeat (6) @(negedge clock);
        // counter wrap from all-ones
        force dut.issue_count = 32'hFFFF_FFFF;
        #1;
        release dut.issue_count;
        set_req(0, 32'd11, 32'd13);
        req_valid = 4'b0001;
        #1;
        check("cwrap_ready", 64'(req_ready), 64'h1);
        push(0, 64'd143);
        @(negedge clock);
        req_valid = '0;
        #1;
        check("cwrap_count", 64'(issue_count), 64'h0);
        repeat (6) @(negedge clock);
        check("q_drained", 64'(q.size()), 64'h0);
        check("sq_drained", 64'(sq.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
